dmem_bus_master: RTL and testbench
==================================

DMEM_BUS_MASTER -- requirements
Module: dmem_bus_master

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32, meaning data/address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning max cycles MREQ is held awaiting ACKD_n before an error response; range 1..255.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  1  pipeline request strobe.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 word, 01 half, 10 byte, 11 reserved.
REQ-009 req_signed  input  1  sign-extend load result (half/byte only).
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-justified.
REQ-012 resp_valid  output  1  one-cycle completion pulse.
REQ-013 resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-014 resp_err  output  1  qualified by resp_valid: misaligned, reserved size, or timeout.
REQ-015 DAD  output  32  bus data address.
REQ-016 MREQ  output  1  bus request, active-high.
REQ-017 WRITE  output  1  bus direction, 1 = store.
REQ-018 SIZE  output  2  bus access size, same encoding as req_size.
REQ-019 ACKD_n  input  1  bus acknowledge, active-low.
REQ-020 DDT  inout  32  bus data; driven by this block only while MREQ=1 and WRITE=1, else high-Z.

Function
REQ-021 SHALL implement states IDLE, BUS, RESP; req_ready=1 only in IDLE.
REQ-022 In IDLE, req_valid=1 SHALL latch addr/size/write/signed/wdata and go to BUS if the request is legal, else go directly to RESP with resp_err=1 and no bus cycle.
REQ-023 Illegal SHALL mean: size 11; word with addr[1:0]!=00; half with addr[0]!=0.
REQ-024 In BUS, MREQ SHALL be 1 and DAD/WRITE/SIZE SHALL hold the latched values stable every cycle until completion.
REQ-025 Store data on DDT SHALL be: word = wdata[31:0]; half = {16'b0, wdata[15:0]}; byte = {24'b0, wdata[7:0]}.
REQ-026 Each rising edge in BUS with ACKD_n=0 SHALL complete the transfer: load captures DDT that edge, state -> RESP, MREQ=0 the following cycle.
REQ-027 Load data SHALL be taken right-justified: word DDT[31:0]; half DDT[15:0]; byte DDT[7:0]; upper bits zero, or copies of bit 15/7 when signed.
REQ-028 A wait counter SHALL clear on entering BUS and increment each BUS cycle with ACKD_n=1; reaching TIMEOUT_CYCLES SHALL go to RESP with resp_err=1, resp_rdata=0, MREQ dropped.
REQ-029 ACKD_n=0 on the same edge the counter reaches TIMEOUT_CYCLES SHALL count as success, not timeout.
REQ-030 RESP SHALL last exactly one cycle (resp_valid=1) then return to IDLE; a request is not accepted in RESP.
REQ-031 Minimum latency: accept at edge N, MREQ high in cycle N+1, ack sampled at edge N+1, resp_valid high in cycle N+2; new accept earliest edge N+3.
REQ-032 ACKD_n SHALL be ignored outside BUS.
REQ-033 req_* inputs SHALL be ignored outside IDLE.

Reset
REQ-034 rst=1 at a rising edge SHALL force IDLE, MREQ=0, WRITE=0, SIZE=00, DAD=0, DDT high-Z, resp_valid=0, resp_err=0, resp_rdata=0, counter=0, req_ready=1 next cycle.
REQ-035 Reset during BUS SHALL abort the transfer with no resp_valid pulse; MREQ low the cycle after the reset edge.

Verification
REQ-036 Word load addr 0x0800_0010, ACKD_n=0 first BUS cycle, DDT=0xDEADBEEF -> SIZE=00, WRITE=0, resp_valid 2 cycles after accept, resp_rdata=0xDEADBEEF, resp_err=0.
REQ-037 Signed byte load addr 0x0800_0003, DDT=0x0000_0080 -> resp_rdata=0xFFFF_FF80; unsigned same -> 0x0000_0080; signed half DDT=0x0000_8001 -> 0xFFFF_8001.
REQ-038 Byte store addr 0xF000_0000 wdata=0x1234_5641, ACKD_n held high 3 cycles then low -> DDT=0x0000_0041, SIZE=10, WRITE=1, MREQ high 4 cycles, one resp_valid, DDT high-Z afterwards.
REQ-039 Word load addr 0x0800_0002 -> MREQ never asserted, resp_valid next cycle with resp_err=1; size 11 at any address -> same.
REQ-040 TIMEOUT_CYCLES=4, ACKD_n held high -> MREQ high exactly 4 cycles, resp_err=1, resp_rdata=0; variant with ACKD_n low on 4th edge -> success.
REQ-041 rst asserted in 2nd BUS cycle -> MREQ=0 next cycle, no resp_valid, req_ready=1, next request completes normally.

Source files
------------

// File: rtl/dmem_bus_master.sv
// Data-memory bus master: accepts one load/store from the pipeline, runs a
// handshaked bus cycle on MREQ/ACKD_n with a timeout, returns a one-cycle response.
module dmem_bus_master #(
  parameter int BIT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [BIT_WIDTH-1:0] req_addr,
  input  logic [BIT_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [BIT_WIDTH-1:0] resp_rdata,
  output logic                 resp_err,
  output logic [BIT_WIDTH-1:0] DAD,
  output logic                 MREQ,
  output logic                 WRITE,
  output logic [1:0]           SIZE,
  input  logic                 ACKD_n,
  inout  wire  [BIT_WIDTH-1:0] DDT
);

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [7:0] TO_LIM  = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  state_e               state_q, state_d;
  logic [BIT_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]           size_q, size_d;
  logic                 write_q, write_d, signed_q, signed_d, err_q, err_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 illegal;
  logic [BIT_WIDTH-1:0] load_data, store_data;

  always_comb begin
    illegal = (req_size == 2'b11) ||
              (req_size == SZ_WORD && req_addr[1:0] != 2'b00) ||
              (req_size == SZ_HALF && req_addr[0]);
  end

  // Bus data is right-justified; loads extend from bit 15/7 when signed.
  always_comb begin
    load_data  = DDT;
    store_data = wdata_q;
    case (size_q)
      SZ_HALF: begin
        load_data  = {{(BIT_WIDTH-16){signed_q & DDT[15]}}, DDT[15:0]};
        store_data = {{(BIT_WIDTH-16){1'b0}}, wdata_q[15:0]};
      end
      SZ_BYTE: begin
        load_data  = {{(BIT_WIDTH-8){signed_q & DDT[7]}}, DDT[7:0]};
        store_data = {{(BIT_WIDTH-8){1'b0}}, wdata_q[7:0]};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    write_d  = write_q;
    signed_d = signed_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          size_d   = req_size;
          write_d  = req_write;
          signed_d = req_signed;
          cnt_d    = 8'd0;
          rdata_d  = '0;
          err_d    = illegal;
          state_d  = illegal ? RESP : BUS;
        end
      end
      BUS: begin
        // An ack on the same edge as the timeout wins.
        if (!ACKD_n) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = write_q ? '0 : load_data;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == TO_LIM) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= 2'b00;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      cnt_q    <= 8'd0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      write_q  <= write_d;
      signed_q <= signed_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign MREQ       = (state_q == BUS);
  assign DAD        = addr_q;
  assign WRITE      = write_q;
  assign SIZE       = size_q;
  assign DDT        = (MREQ && write_q) ? store_data : 'z;

endmodule

// File: tb/tb_dmem_bus_master.sv
// Directed bench for dmem_bus_master: loads, stores, alignment errors,
// timeout (TIMEOUT_CYCLES=4), reset during a bus cycle.
module tb_dmem_bus_master;
  logic        clk = 1'b0;
  logic        rst, req_valid, req_write, req_signed, ACKD_n;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, MREQ, WRITE;
  logic [31:0] resp_rdata, DAD;
  logic [1:0]  SIZE;
  wire  [31:0] DDT;
  logic        ddt_en = 1'b0;
  logic [31:0] ddt_drv = '0;

  int errors = 0;
  int checks = 0;

  // Observations filled in by run_xfer
  int          o_mreq, o_resp, o_lat;
  logic [31:0] o_rdata, o_ddt, o_dad;
  logic        o_err, o_write, o_ready_acc, o_ready_bus, o_ready_after;
  logic [1:0]  o_size;

  assign DDT = ddt_en ? ddt_drv : 'z;

  always #5 clk = ~clk;

  dmem_bus_master #(.BIT_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .DAD(DAD), .MREQ(MREQ),
    .WRITE(WRITE), .SIZE(SIZE), .ACKD_n(ACKD_n), .DDT(DDT)
  );

  // Issues one request and plays the bus slave: acks after ack_after
  // MREQ-high cycles (-1 = never), supplies dv on loads.
  task automatic run_xfer(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int ack_after, input logic [31:0] dv);
    o_mreq = 0; o_resp = 0; o_lat = -1; o_rdata = '0; o_err = 1'b0;
    o_ddt = '0; o_dad = '0; o_size = 2'b00; o_write = 1'b0;
    o_ready_bus = 1'b0; o_ready_after = 1'b0;
    @(posedge clk); #1;
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(negedge clk);
    o_ready_acc = req_ready;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_size = 2'b11; req_wdata = '1;
    for (int i = 0; i < 40; i++) begin
      if (MREQ) begin
        ACKD_n = (o_mreq == ack_after) ? 1'b0 : 1'b1;
        if (!w) begin ddt_en = 1'b1; ddt_drv = dv; end
        if (o_mreq == 0) begin o_size = SIZE; o_write = WRITE; o_dad = DAD; end
        o_mreq++;
      end else begin
        ACKD_n = 1'b1; ddt_en = 1'b0;
      end
      @(negedge clk);
      if (MREQ && w) o_ddt = DDT;
      if (MREQ && req_ready) o_ready_bus = 1'b1;
      if (resp_valid) begin
        o_resp++; o_rdata = resp_rdata; o_err = resp_err;
        if (o_lat < 0) o_lat = i + 1;
      end else if (o_lat >= 0) begin
        o_ready_after = req_ready;
        break;
      end
      @(posedge clk); #1;
    end
    ACKD_n = 1'b1; ddt_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; ACKD_n = 1'b1; req_write = 1'b0;
    req_size = 2'b00; req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", req_ready); end
    checks++; if ({MREQ, WRITE, SIZE} !== 4'b0) begin errors++; $display("FAIL rst_bus got %b exp 0000", {MREQ, WRITE, SIZE}); end
    checks++; if (DAD !== 32'h0) begin errors++; $display("FAIL rst_dad got %h exp 0", DAD); end
    checks++; if ({resp_valid, resp_err} !== 2'b00 || resp_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_resp got v=%b e=%b d=%h exp 0", resp_valid, resp_err, resp_rdata); end
  endtask

  task automatic test_word_load;
    run_xfer(1'b0, 2'b00, 1'b0, 32'h0800_0010, 32'h0, 0, 32'hDEAD_BEEF);
    checks++; if (o_ready_acc !== 1'b1) begin errors++; $display("FAIL wl_ready got %b exp 1", o_ready_acc); end
    checks++; if (o_size !== 2'b00 || o_write !== 1'b0) begin errors++; $display("FAIL wl_ctl got size=%b wr=%b exp 00/0", o_size, o_write); end
    checks++; if (o_dad !== 32'h0800_0010) begin errors++; $display("FAIL wl_dad got %h exp 08000010", o_dad); end
    checks++; if (o_lat !== 2) begin errors++; $display("FAIL wl_latency got %0d exp 2", o_lat); end
    checks++; if (o_rdata !== 32'hDEAD_BEEF || o_err !== 1'b0) begin errors++; $display("FAIL wl_data got %h err=%b exp deadbeef/0", o_rdata, o_err); end
    checks++; if (o_mreq !== 1) begin errors++; $display("FAIL wl_mreq got %0d exp 1", o_mreq); end
    checks++; if (o_ready_bus !== 1'b0) begin errors++; $display("FAIL wl_ready_in_bus got %b exp 0", o_ready_bus); end
  endtask

  task automatic test_ext_load;
    run_xfer(1'b0, 2'b10, 1'b1, 32'h0800_0003, 32'h0, 0, 32'h0000_0080);
    checks++; if (o_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL sbyte got %h exp ffffff80", o_rdata); end
    run_xfer(1'b0, 2'b10, 1'b0, 32'h0800_0003, 32'h0, 0, 32'h0000_0080);
    checks++; if (o_rdata !== 32'h0000_0080) begin errors++; $display("FAIL ubyte got %h exp 00000080", o_rdata); end
    run_xfer(1'b0, 2'b01, 1'b1, 32'h0800_0002, 32'h0, 1, 32'h0000_8001);
    checks++; if (o_rdata !== 32'hFFFF_8001) begin errors++; $display("FAIL shalf got %h exp ffff8001", o_rdata); end
    run_xfer(1'b0, 2'b01, 1'b0, 32'h0800_0006, 32'h0, 0, 32'h1234_9ABC);
    checks++; if (o_rdata !== 32'h0000_9ABC) begin errors++; $display("FAIL uhalf_upper got %h exp 00009abc", o_rdata); end
    run_xfer(1'b0, 2'b10, 1'b1, 32'h0800_0001, 32'h0, 0, 32'hFFFF_FF7F);
    checks++; if (o_rdata !== 32'h0000_007F) begin errors++; $display("FAIL sbyte_pos got %h exp 0000007f", o_rdata); end
  endtask

  task automatic test_store;
    run_xfer(1'b1, 2'b10, 1'b0, 32'hF000_0000, 32'h1234_5641, 3, 32'h0);
    checks++; if (o_ddt !== 32'h0000_0041) begin errors++; $display("FAIL sb_ddt got %h exp 00000041", o_ddt); end
    checks++; if (o_size !== 2'b10 || o_write !== 1'b1) begin errors++; $display("FAIL sb_ctl got size=%b wr=%b exp 10/1", o_size, o_write); end
    checks++; if (o_mreq !== 4) begin errors++; $display("FAIL sb_mreq got %0d exp 4", o_mreq); end
    checks++; if (o_resp !== 1 || o_err !== 1'b0 || o_rdata !== 32'h0) begin
      errors++; $display("FAIL sb_resp got n=%0d e=%b d=%h exp 1/0/0", o_resp, o_err, o_rdata); end
    // Drive a pattern after the store: it reads back intact only if the DUT released DDT
    ddt_en = 1'b1; ddt_drv = 32'hA5A5_A5A5;
    #1;
    checks++; if (DDT !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_ddt_release got %h exp a5a5a5a5", DDT); end
    ddt_en = 1'b0;
    run_xfer(1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'hABCD_1234, 0, 32'h0);
    checks++; if (o_ddt !== 32'h0000_1234) begin errors++; $display("FAIL sh_ddt got %h exp 00001234", o_ddt); end
    run_xfer(1'b1, 2'b00, 1'b0, 32'h0000_0104, 32'hCAFE_F00D, 1, 32'h0);
    checks++; if (o_ddt !== 32'hCAFE_F00D || o_mreq !== 2) begin errors++; $display("FAIL sw_ddt got %h mreq=%0d exp cafef00d/2", o_ddt, o_mreq); end
  endtask

  task automatic test_illegal;
    run_xfer(1'b0, 2'b00, 1'b0, 32'h0800_0002, 32'h0, 0, 32'h1111_1111);
    checks++; if (o_mreq !== 0 || o_lat !== 1 || o_err !== 1'b1 || o_rdata !== 32'h0) begin
      errors++; $display("FAIL misalign_word got mreq=%0d lat=%0d err=%b d=%h exp 0/1/1/0", o_mreq, o_lat, o_err, o_rdata); end
    run_xfer(1'b1, 2'b11, 1'b0, 32'h0000_0000, 32'h5, 0, 32'h0);
    checks++; if (o_mreq !== 0 || o_lat !== 1 || o_err !== 1'b1) begin
      errors++; $display("FAIL size11 got mreq=%0d lat=%0d err=%b exp 0/1/1", o_mreq, o_lat, o_err); end
    run_xfer(1'b0, 2'b01, 1'b0, 32'h0000_0011, 32'h0, 0, 32'h0);
    checks++; if (o_mreq !== 0 || o_err !== 1'b1) begin
      errors++; $display("FAIL misalign_half got mreq=%0d err=%b exp 0/1", o_mreq, o_err); end
    run_xfer(1'b0, 2'b10, 1'b0, 32'h0000_0013, 32'h0, 0, 32'h0000_0033);
    checks++; if (o_mreq !== 1 || o_err !== 1'b0 || o_rdata !== 32'h33) begin
      errors++; $display("FAIL odd_byte_ok got mreq=%0d err=%b d=%h exp 1/0/33", o_mreq, o_err, o_rdata); end
  endtask

  task automatic test_timeout;
    run_xfer(1'b0, 2'b00, 1'b0, 32'h0000_0020, 32'h0, -1, 32'h7777_7777);
    checks++; if (o_mreq !== 4) begin errors++; $display("FAIL to_mreq got %0d exp 4", o_mreq); end
    checks++; if (o_resp !== 1 || o_err !== 1'b1 || o_rdata !== 32'h0) begin
      errors++; $display("FAIL to_resp got n=%0d e=%b d=%h exp 1/1/0", o_resp, o_err, o_rdata); end
    run_xfer(1'b0, 2'b00, 1'b0, 32'h0000_0024, 32'h0, 3, 32'h7777_7777);
    checks++; if (o_mreq !== 4 || o_err !== 1'b0 || o_rdata !== 32'h7777_7777) begin
      errors++; $display("FAIL to_edge_ack got mreq=%0d e=%b d=%h exp 4/0/77777777", o_mreq, o_err, o_rdata); end
  endtask

  task automatic test_ack_idle;
    int seen = 0;
    @(posedge clk); #1;
    ACKD_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (MREQ || resp_valid || !req_ready) seen++;
    end
    ACKD_n = 1'b1;
    checks++; if (seen !== 0) begin errors++; $display("FAIL ack_idle got %0d disturbed cycles exp 0", seen); end
  endtask

  task automatic test_reset_in_bus;
    int rv = 0;
    @(posedge clk); #1;
    req_write = 1'b0; req_size = 2'b00; req_addr = 32'h0000_0040; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (MREQ !== 1'b1) begin errors++; $display("FAIL rb_pre got mreq=%b exp 1", MREQ); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (MREQ !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rb_post got mreq=%b ready=%b exp 0/1", MREQ, req_ready); end
    if (resp_valid) rv++;
    repeat (5) begin @(negedge clk); if (resp_valid) rv++; end
    checks++; if (rv !== 0) begin errors++; $display("FAIL rb_no_resp got %0d pulses exp 0", rv); end
    run_xfer(1'b0, 2'b00, 1'b0, 32'h0000_0044, 32'h0, 0, 32'h0BAD_F00D);
    checks++; if (o_lat !== 2 || o_rdata !== 32'h0BAD_F00D || o_err !== 1'b0) begin
      errors++; $display("FAIL rb_next got lat=%0d d=%h e=%b exp 2/0badf00d/0", o_lat, o_rdata, o_err); end
  endtask

  task automatic test_back_to_back;
    run_xfer(1'b1, 2'b00, 1'b0, 32'h0000_0080, 32'h0102_0304, 0, 32'h0);
    checks++; if (o_ready_after !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", o_ready_after); end
    run_xfer(1'b0, 2'b00, 1'b0, 32'h0000_0080, 32'h0, 0, 32'h0102_0304);
    checks++; if (o_lat !== 2 || o_resp !== 1 || o_rdata !== 32'h0102_0304) begin
      errors++; $display("FAIL b2b_load got lat=%0d n=%0d d=%h exp 2/1/01020304", o_lat, o_resp, o_rdata); end
  endtask

  initial begin
    test_reset;
    test_word_load;
    test_ext_load;
    test_store;
    test_illegal;
    test_timeout;
    test_ack_idle;
    test_reset_in_bus;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
